// File: rtl/regfile_mrmw.sv
// Multi-read, multi-write register file with optional registered read,
// write-to-read bypass, hardwired zero register and per-register busy scoreboard.
module regfile_mrmw #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int RD_REG   = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [DEPTH-1:0]         busy_vec
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;

  genvar gi;

  // One storage slot per register; addresses past DEPTH never decode to a slot.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign mem_q[gi]  = '0;
        assign busy_q[gi] = 1'b0;
      end else begin : g_live
        logic [WIDTH-1:0] data_reg, data_next;
        logic             busy_reg, busy_next;

        // Ascending scan lets the highest-index write port win; reserve overrides release.
        always_comb begin
          data_next = data_reg;
          busy_next = busy_reg;
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(gi))) begin
              data_next = wr_data[p*WIDTH +: WIDTH];
              busy_next = 1'b0;
            end
          end
          if (rsv_en && (rsv_addr == AW'(gi)))
            busy_next = 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            data_reg <= data_next;
            busy_reg <= busy_next;
          end
        end

        assign mem_q[gi]  = data_reg;
        assign busy_q[gi] = busy_reg;
      end
    end
  endgenerate

  assign busy_vec = busy_q;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data_comb;
      logic             busy_comb;
      logic             in_range;

      assign addr = rd_addr[gi*AW +: AW];

      always_comb begin
        data_comb = '0;
        busy_comb = 1'b0;
        in_range  = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
          if (addr == AW'(r)) begin
            data_comb = mem_q[r];
            busy_comb = busy_q[r];
            in_range  = 1'b1;
          end
        end
        // Forwarded data is final, so the pending reservation no longer blocks the reader.
        if (BYPASS != 0 && in_range && !(ZERO_REG != 0 && addr == '0)) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
              data_comb = wr_data[w*WIDTH +: WIDTH];
              busy_comb = 1'b0;
            end
          end
        end
      end

      if (RD_REG != 0) begin : g_sync
        logic [WIDTH-1:0] data_reg;
        logic             valid_reg;
        logic             busy_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end else begin
            valid_reg <= rd_en[gi];
            if (rd_en[gi]) begin
              data_reg <= data_comb;
              busy_reg <= busy_comb;
            end
          end
        end

        assign rd_data[gi*WIDTH +: WIDTH] = data_reg;
        assign rd_valid[gi]               = valid_reg;
        assign rd_busy[gi]                = busy_reg;
      end else begin : g_async
        assign rd_data[gi*WIDTH +: WIDTH] = data_comb;
        assign rd_valid[gi]               = rd_en[gi];
        assign rd_busy[gi]                = busy_comb;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mrmw.sv
// Directed and randomised checks of regfile_mrmw: a combinational-read/bypass
// instance and a registered-read/no-bypass instance share one stimulus stream.
module tb_regfile_mrmw;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AB = 4;
  localparam int NR = 2;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NW-1:0]   wr_en;
  logic [NW*AB-1:0] wr_addr;
  logic [NW*W-1:0] wr_data;
  logic [NR-1:0]   rd_en;
  logic [NR*AB-1:0] rd_addr;
  logic            rsv_en;
  logic [AB-1:0]   rsv_addr;

  logic [NR*W-1:0] rd_data_c, rd_data_r;
  logic [NR-1:0]   rd_valid_c, rd_valid_r, rd_busy_c, rd_busy_r;
  logic [D-1:0]    busy_vec_c, busy_vec_r;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mrmw #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW),
                 .RD_REG(0), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .rd_busy(rd_busy_c), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_c)
  );

  regfile_mrmw #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW),
                 .RD_REG(1), .BYPASS(0), .ZERO_REG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_r), .rd_valid(rd_valid_r),
    .rd_busy(rd_busy_r), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AB-1:0] a, input logic [W-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AB +: AB] = a;
    wr_data[p*W +: W] = d;
  endtask

  task automatic set_rd(input int p, input logic [AB-1:0] a, input logic en);
    rd_en[p] = en;
    rd_addr[p*AB +: AB] = a;
  endtask

  function automatic logic [W-1:0] rdc(input int p);
    return rd_data_c[p*W +: W];
  endfunction

  function automatic logic [W-1:0] rdr(input int p);
    return rd_data_r[p*W +: W];
  endfunction

  // Reference state for the soak
  logic [W-1:0]    mem_m [D];
  logic [D-1:0]    busy_m;
  logic [NR*W-1:0] exp_d, er_d;
  logic [NR-1:0]   exp_b, er_b, er_v;

  initial begin
    logic [AB-1:0] a;
    logic [W-1:0]  v, rv;
    logic          b, rb;

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy_vec", 32'(busy_vec_c), 32'h0);
    check("rst_rd_valid_r", 32'(rd_valid_r), 32'h0);
    check("rst_rd_data_r", 32'(rd_data_r), 32'h0);
    $display("TX reset released");

    // Preload r3 and reserve it, then pull reset mid-cycle
    set_wr(0, 4'd3, 16'h1234); rsv_en = 1'b1; rsv_addr = 4'd3;
    tick(); idle();
    set_rd(0, 4'd3, 1'b1);
    #1;
    check("pre_r3_c", 32'(rdc(0)), 32'h1234);
    check("pre_busy_vec", 32'(busy_vec_c), 32'h0008);
    tick();
    check("pre_r3_r", 32'(rdr(0)), 32'h1234);
    check("pre_valid_r", 32'(rd_valid_r), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_r3_c", 32'(rdc(0)), 32'h0);
    check("arst_busy_vec", 32'(busy_vec_c), 32'h0);
    check("arst_valid_r", 32'(rd_valid_r), 32'h0);
    check("arst_r3_r", 32'(rdr(0)), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle();
    $display("TX mid-cycle async reset");

    // Basic write then dual-port read
    set_wr(0, 4'd5, 16'hBEEF);
    tick(); idle();
    set_rd(0, 4'd5, 1'b1); set_rd(1, 4'd5, 1'b1);
    #1;
    check("basic_p0_c", 32'(rdc(0)), 32'hBEEF);
    check("basic_p1_c", 32'(rdc(1)), 32'hBEEF);
    check("basic_valid_c", 32'(rd_valid_c), 32'h3);
    tick();
    check("basic_p0_r", 32'(rdr(0)), 32'hBEEF);
    check("basic_p1_r", 32'(rdr(1)), 32'hBEEF);
    check("basic_valid_r", 32'(rd_valid_r), 32'h3);
    rd_en = '0;
    tick();
    check("hold_valid_r", 32'(rd_valid_r), 32'h0);
    check("hold_data_r", 32'(rdr(0)), 32'hBEEF);
    $display("TX write r5=BEEF, read both ports");

    // Two ports write r7 in the same cycle while it is read
    idle();
    set_wr(0, 4'd7, 16'h1111); set_wr(1, 4'd7, 16'h2222); set_rd(0, 4'd7, 1'b1);
    #1;
    check("bypass_c", 32'(rdc(0)), 32'h2222);
    tick();
    check("nobypass_r", 32'(rdr(0)), 32'h0000);
    idle(); set_rd(0, 4'd7, 1'b1);
    #1;
    check("conflict_mem_c", 32'(rdc(0)), 32'h2222);
    tick();
    check("conflict_mem_r", 32'(rdr(0)), 32'h2222);
    $display("TX dual write r7, bypass and conflict");

    // Zero register ignores writes and reservations
    idle();
    set_wr(0, 4'd0, 16'hFFFF); rsv_en = 1'b1; rsv_addr = 4'd0; set_rd(0, 4'd0, 1'b1);
    #1;
    check("zero_nobypass_c", 32'(rdc(0)), 32'h0);
    tick(); idle(); set_rd(0, 4'd0, 1'b0);
    #1;
    check("zero_read_c", 32'(rdc(0)), 32'h0);
    check("zero_busy", 32'(busy_vec_c[0]), 32'h0);
    $display("TX write/reserve r0");

    // Scoreboard
    rsv_en = 1'b1; rsv_addr = 4'd4;
    tick(); idle(); set_rd(1, 4'd4, 1'b0);
    #1;
    check("rsv_busy_vec", 32'(busy_vec_c), 32'h0010);
    check("rsv_rd_busy", 32'(rd_busy_c[1]), 32'h1);
    set_wr(0, 4'd4, 16'h00AA);
    #1;
    check("rel_fwd_busy", 32'(rd_busy_c[1]), 32'h0);
    check("rel_fwd_data", 32'(rdc(1)), 32'h00AA);
    tick(); idle(); set_rd(1, 4'd4, 1'b0);
    #1;
    check("rel_busy_vec", 32'(busy_vec_c), 32'h0);
    check("rel_data", 32'(rdc(1)), 32'h00AA);
    rsv_en = 1'b1; rsv_addr = 4'd4; set_wr(1, 4'd4, 16'h00BB);
    tick(); idle(); set_rd(1, 4'd4, 1'b0);
    #1;
    check("rsvwr_busy_vec", 32'(busy_vec_c), 32'h0010);
    check("rsvwr_data", 32'(rdc(1)), 32'h00BB);
    rsv_en = 1'b1; rsv_addr = 4'd4;
    tick(); idle();
    #1;
    check("rsv_again_busy", 32'(busy_vec_c), 32'h0010);
    $display("TX scoreboard reserve/release on r4");

    // Randomised soak against the reference model from a clean reset
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int r = 0; r < D; r++) mem_m[r] = '0;
    busy_m = '0; er_d = '0; er_b = '0; er_v = '0;
    for (int c = 0; c < 2000; c++) begin
      wr_en    = 2'($urandom);
      wr_addr  = 8'($urandom);
      wr_data  = 32'($urandom);
      rd_en    = 2'($urandom);
      rd_addr  = 8'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 4'($urandom);
      #1;
      for (int p = 0; p < NR; p++) begin
        a  = rd_addr[p*AB +: AB];
        rv = (a == 0) ? '0 : mem_m[a];
        rb = (a == 0) ? 1'b0 : busy_m[a];
        v = rv; b = rb;
        for (int w = 0; w < NW; w++)
          if (wr_en[w] && wr_addr[w*AB +: AB] == a && a != 0) begin
            v = wr_data[w*W +: W];
            b = 1'b0;
          end
        exp_d[p*W +: W] = v;
        exp_b[p] = b;
        if (rd_en[p]) begin
          er_d[p*W +: W] = rv;
          er_b[p] = rb;
        end
      end
      er_v = rd_en;
      check("soak_data_c", rd_data_c, exp_d);
      check("soak_valid_c", 32'(rd_valid_c), 32'(rd_en));
      check("soak_busy_c", 32'(rd_busy_c), 32'(exp_b));
      check("soak_busy_vec", 32'(busy_vec_c), 32'(busy_m));
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && wr_addr[w*AB +: AB] != 0) begin
          mem_m[wr_addr[w*AB +: AB]] = wr_data[w*W +: W];
          busy_m[wr_addr[w*AB +: AB]] = 1'b0;
        end
      if (rsv_en && rsv_addr != 0) busy_m[rsv_addr] = 1'b1;
      tick();
      check("soak_data_r", rd_data_r, er_d);
      check("soak_valid_r", 32'(rd_valid_r), 32'(er_v));
      check("soak_busy_r", 32'(rd_busy_r), 32'(er_b));
    end
    idle();
    $display("TX random soak of 2000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
